// File: rtl/draw_cmd_pkg.sv
// Shared opcode map, FSM state encoding and field widths for the draw-command dispatcher.
package draw_cmd_pkg;

  localparam int OP_W      = 4;
  localparam int ENG_IDX_W = 2;

  localparam logic [OP_W-1:0] OP_SPIXEL  = 4'h0;
  localparam logic [OP_W-1:0] OP_RECT_SP = 4'h1;
  localparam logic [OP_W-1:0] OP_RECT_PX = 4'h9;
  localparam logic [OP_W-1:0] OP_CHAR    = 4'hA;

  typedef enum logic [2:0] {IDLE, POP, DECODE, RUN, WAIT_DONE} state_e;

  // Decoded opcode: hit = known opcode, idx = engine that executes it.
  typedef struct packed {
    logic                 hit;
    logic [ENG_IDX_W-1:0] idx;
  } eng_sel_t;

  function automatic eng_sel_t op_to_eng(input logic [OP_W-1:0] op);
    eng_sel_t sel;
    sel = '0;
    case (op)
      OP_SPIXEL:  sel = '{hit: 1'b1, idx: 2'd0};
      OP_RECT_SP: sel = '{hit: 1'b1, idx: 2'd1};
      OP_RECT_PX: sel = '{hit: 1'b1, idx: 2'd2};
      OP_CHAR:    sel = '{hit: 1'b1, idx: 2'd3};
      default:    sel = '0;
    endcase
    return sel;
  endfunction

  // Opcodes whose command may be split in two words; bit0 = 0 marks the first half.
  function automatic logic is_split_op(input logic [OP_W-1:0] op);
    return (op == OP_RECT_PX) || (op == OP_CHAR);
  endfunction

endpackage

// File: rtl/draw_cmd_dispatcher_wport.sv
// Owner-indexed VGA RAM write-port mux; flags writes from engines that do not hold the port.
module draw_wport_mux
  import draw_cmd_pkg::*;
#(
  parameter int NUM_ENG    = 4,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ENG_IDX_W-1:0]             owner_i,
  input  logic                             owner_vld_i,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0]    eng_addr_i,
  input  logic [NUM_ENG*DATA_WIDTH-1:0]    eng_data_i,
  input  logic [NUM_ENG-1:0]               eng_wren_i,
  output logic [ADDR_WIDTH-1:0]            ram_addr_o,
  output logic [DATA_WIDTH-1:0]            ram_data_o,
  output logic                             ram_wren_o,
  output logic                             err_collision_o
);

  logic [NUM_ENG-1:0] gnt;
  logic               err_col_d, err_col_q;

  // One-hot grant; empty when nobody owns the port.
  always_comb begin
    gnt = '0;
    if (owner_vld_i) gnt[owner_i] = 1'b1;
  end

  // AND-OR select of the granted slice; zero-latency path from engine to RAM.
  always_comb begin
    ram_addr_o = '0;
    ram_data_o = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (gnt[i]) begin
        ram_addr_o |= eng_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_data_o |= eng_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ram_wren_o = |(eng_wren_i & gnt);
    err_col_d  = |(eng_wren_i & ~gnt);
  end

  // Collision flag is registered so it never feeds back combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_col_q <= 1'b0;
    else        err_col_q <= err_col_d;
  end

  assign err_collision_o = err_col_q;

endmodule

// File: rtl/draw_cmd_dispatcher.sv
// Pops draw commands, starts exactly one engine per command and grants it the RAM write port.
module draw_cmd_dispatcher
  import draw_cmd_pkg::*;
#(
  parameter int          CMD_WIDTH  = 32,
  parameter int          NUM_ENG    = 4,
  parameter int          ADDR_WIDTH = 19,
  parameter int          DATA_WIDTH = 8,
  parameter logic [23:0] TIMEOUT    = 24'd4000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          ff_empty,
  output logic                          ff_rden,
  input  logic [CMD_WIDTH-1:0]          ff_rdat,
  input  logic                          ff_rvld,
  output logic [CMD_WIDTH-1:0]          eng_cmd,
  output logic [NUM_ENG-1:0]            eng_vld,
  input  logic [NUM_ENG-1:0]            eng_done,
  input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr,
  input  logic [NUM_ENG*DATA_WIDTH-1:0] eng_data,
  input  logic [NUM_ENG-1:0]            eng_wren,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_data,
  output logic                          ram_wren,
  output logic                          busy,
  output logic                          err_opcode,
  output logic                          err_timeout,
  output logic                          err_collision
);

  state_e                state_q, state_d;
  logic [ENG_IDX_W-1:0]  owner_q, owner_d;
  logic                  own_vld_q, own_vld_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic [23:0]           cnt_q, cnt_d;
  logic [OP_W-1:0]       op;
  eng_sel_t              sel;
  logic                  tmo;

  assign op  = cmd_q[CMD_WIDTH-1 -: OP_W];
  assign sel = op_to_eng(op);
  assign tmo = (cnt_q == TIMEOUT);

  // State, owner and command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      own_vld_q <= 1'b0;
      cmd_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      own_vld_q <= own_vld_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and strobes. rst_n gates the pop so the FIFO is untouched while held in reset.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    own_vld_d   = own_vld_q;
    cmd_d       = cmd_q;
    ff_rden     = 1'b0;
    eng_vld     = '0;
    err_opcode  = 1'b0;
    err_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        ff_rden = en & ~ff_empty & rst_n;
        if (ff_rden) state_d = POP;
      end
      POP: begin
        if (ff_rvld) begin
          cmd_d   = ff_rdat;
          state_d = DECODE;
        end else if (tmo) begin
          err_timeout = 1'b1;
          state_d     = IDLE;
        end
      end
      DECODE: begin
        if (sel.hit) begin
          owner_d   = sel.idx;
          own_vld_d = 1'b1;
          state_d   = RUN;
        end else begin
          err_opcode = 1'b1;
          state_d    = IDLE;
        end
      end
      RUN: begin
        eng_vld[owner_q] = 1'b1;
        // First half of a split command: engine finishes silently, release immediately.
        if (is_split_op(op) && !cmd_q[0]) begin
          owner_d   = '0;
          own_vld_d = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // done wins over a coincident timeout
        if (eng_done[owner_q]) begin
          owner_d   = '0;
          own_vld_d = 1'b0;
          state_d   = IDLE;
        end else if (tmo) begin
          err_timeout = 1'b1;
          owner_d     = '0;
          own_vld_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Counter restarts on every state change and only runs in the two wait states.
    if ((state_d != state_q) || !((state_q == POP) || (state_q == WAIT_DONE))) cnt_d = '0;
    else cnt_d = cnt_q + 24'd1;
  end

  assign eng_cmd = cmd_q;
  assign busy    = (state_q != IDLE);

  draw_wport_mux #(
    .NUM_ENG   (NUM_ENG),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_wport (
    .clk            (clk),
    .rst_n          (rst_n),
    .owner_i        (owner_q),
    .owner_vld_i    (own_vld_q),
    .eng_addr_i     (eng_addr),
    .eng_data_i     (eng_data),
    .eng_wren_i     (eng_wren),
    .ram_addr_o     (ram_addr),
    .ram_data_o     (ram_data),
    .ram_wren_o     (ram_wren),
    .err_collision_o(err_collision)
  );

endmodule

// File: tb/tb_draw_cmd_dispatcher.sv
// Scoreboard bench for draw_cmd_dispatcher: directed commands, monitor checks every output event.
module tb_draw_cmd_dispatcher;

  localparam int CW = 32;
  localparam int NE = 4;
  localparam int AW = 19;
  localparam int DW = 8;

  localparam logic [1:0] EV_START = 2'd0;
  localparam logic [1:0] EV_OP    = 2'd1;
  localparam logic [1:0] EV_TMO   = 2'd2;
  localparam logic [1:0] EV_COL   = 2'd3;

  typedef struct packed {
    logic [1:0]    kind;
    logic [NE-1:0] vld;
    logic [CW-1:0] cmd;
  } ev_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic                ff_empty = 1'b1;
  logic                ff_rden;
  logic [CW-1:0]       ff_rdat = '0;
  logic                ff_rvld = 1'b0;
  logic [CW-1:0]       eng_cmd;
  logic [NE-1:0]       eng_vld;
  logic [NE-1:0]       eng_done = '0;
  logic [NE*AW-1:0]    eng_addr = '0;
  logic [NE*DW-1:0]    eng_data = '0;
  logic [NE-1:0]       eng_wren = '0;
  logic [AW-1:0]       ram_addr;
  logic [DW-1:0]       ram_data;
  logic                ram_wren;
  logic                busy;
  logic                err_opcode, err_timeout, err_collision;

  int  n_vec = 0;
  int  n_err = 0;
  ev_t sb[$];
  logic [CW-1:0] fifo[$];

  always #5 clk = ~clk;

  draw_cmd_dispatcher #(
    .CMD_WIDTH(CW), .NUM_ENG(NE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(24'd16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ff_empty(ff_empty), .ff_rden(ff_rden),
    .ff_rdat(ff_rdat), .ff_rvld(ff_rvld), .eng_cmd(eng_cmd), .eng_vld(eng_vld),
    .eng_done(eng_done), .eng_addr(eng_addr), .eng_data(eng_data), .eng_wren(eng_wren),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .busy(busy),
    .err_opcode(err_opcode), .err_timeout(err_timeout), .err_collision(err_collision)
  );

  // FIFO model: data one cycle after the pop strobe, empty flag tracks the queue.
  always @(posedge clk) begin
    ff_rvld <= 1'b0;
    if (ff_rden && fifo.size() > 0) begin
      ff_rdat <= fifo.pop_front();
      ff_rvld <= 1'b1;
    end
    ff_empty <= (fifo.size() == 0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic sb_check(input string nm, input ev_t act);
    ev_t exp;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got unexpected event %h expected none (t=%0t)", nm, act, $time);
    end else begin
      exp = sb.pop_front();
      chk(nm, act, exp);
    end
  endtask

  // Monitor: every event the DUT presents is matched against the scoreboard in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_opcode)    sb_check("mon_err_opcode", '{EV_OP, 4'b0000, 32'h0});
      if (err_timeout)   sb_check("mon_err_timeout", '{EV_TMO, 4'b0000, 32'h0});
      if (err_collision) sb_check("mon_err_collision", '{EV_COL, 4'b0000, 32'h0});
      if (eng_vld != '0) sb_check("mon_eng_start", '{EV_START, eng_vld, eng_cmd});
    end
  end

  task automatic expect_ev(input logic [1:0] k, input logic [NE-1:0] v, input logic [CW-1:0] c);
    sb.push_back('{k, v, c});
  endtask

  task automatic neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic at_pos;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rden(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (!ff_rden && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(nm, ff_rden, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] c0;
    int bad;
    c0 = {4'h0, 10'd3, 10'd4, 8'h0f};

    // reset state
    neg(2);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {ff_rden, eng_vld, ram_wren, ram_addr, eng_cmd}, '0);
    at_pos;
    rst_n = 1'b1;

    // en low blocks the pop
    fifo.push_back(c0);
    expect_ev(EV_START, 4'b0001, c0);
    neg(3);
    chk("en_low_block", ff_rden, 1'b0);
    at_pos;
    en = 1'b1;

    // superpixel, done 10 cycles after start
    wait_rden("t1_pop");
    neg(3);
    chk("t1_vld", eng_vld, 4'b0001);
    fifo.push_back(32'h9000_1230);
    fifo.push_back(32'h9000_1231);
    expect_ev(EV_START, 4'b0100, 32'h9000_1230);
    expect_ev(EV_START, 4'b0100, 32'h9000_1231);
    bad = 0;
    repeat (9) begin
      neg(1);
      if (ff_rden) bad++;
    end
    chk("t1_hold", bad, 0);
    at_pos;
    eng_done = 4'b0001;
    neg(1);
    chk("t1_hold_done", ff_rden, 1'b0);
    at_pos;
    eng_done = '0;
    neg(1);
    chk("t1_next_pop", ff_rden, 1'b1);

    // half then full RECT_PX
    neg(3);
    chk("t2_vld1", eng_vld, 4'b0100);
    neg(1);
    chk("t2_pop2", ff_rden, 1'b1);
    neg(3);
    chk("t2_vld2", eng_vld, 4'b0100);
    at_pos;
    eng_done = 4'b0010;
    at_pos;
    eng_done = '0;
    neg(1);
    chk("t2_ignore_other", busy, 1'b1);
    at_pos;
    eng_done = 4'b0100;
    at_pos;
    eng_done = '0;
    neg(1);
    chk("t2_done", busy, 1'b0);

    // unknown opcode, FIFO keeps draining
    fifo.push_back(32'h5000_0000);
    fifo.push_back(32'h1000_00AB);
    expect_ev(EV_OP, 4'b0000, 32'h0);
    expect_ev(EV_START, 4'b0010, 32'h1000_00AB);
    wait_rden("t3_pop");
    neg(2);
    chk("t3_errop", err_opcode, 1'b1);
    neg(1);
    chk("t3_single", {err_opcode, eng_vld}, 5'b0);
    chk("t3_drain", ff_rden, 1'b1);
    neg(3);
    chk("t3_vld", eng_vld, 4'b0010);
    at_pos;
    eng_done = 4'b0010;
    at_pos;
    eng_done = '0;
    neg(1);
    chk("t3_idle", busy, 1'b0);

    // engine 3 owns the port while engine 0 writes
    fifo.push_back(32'hA000_0001);
    expect_ev(EV_START, 4'b1000, 32'hA000_0001);
    wait_rden("t4_pop");
    neg(3);
    chk("t4_vld", eng_vld, 4'b1000);
    at_pos;
    eng_addr[3*AW +: AW] = 19'h00ABC;
    eng_data[3*DW +: DW] = 8'h3C;
    eng_addr[0*AW +: AW] = 19'h00100;
    eng_data[0*DW +: DW] = 8'h55;
    eng_wren = 4'b1001;
    expect_ev(EV_COL, 4'b0000, 32'h0);
    neg(1);
    chk("t4_owner_wr", {ram_wren, ram_addr, ram_data}, {1'b1, 19'h00ABC, 8'h3C});
    at_pos;
    eng_wren = 4'b0001;
    expect_ev(EV_COL, 4'b0000, 32'h0);
    neg(1);
    chk("t4_drop_wren", ram_wren, 1'b0);
    chk("t4_addr_owner", ram_addr, 19'h00ABC);
    at_pos;
    eng_wren = 4'b1000;
    eng_addr[3*AW +: AW] = 19'h00ABD;
    eng_done = 4'b1000;
    neg(1);
    chk("t4_wr_with_done", {ram_wren, ram_addr}, {1'b1, 19'h00ABD});
    at_pos;
    eng_wren = '0;
    eng_done = '0;
    neg(1);
    chk("t4_no_owner", {ram_wren, ram_addr, ram_data, busy}, '0);
    eng_addr = '0;
    eng_data = '0;

    // no done: timeout after 16 cycles in WAIT_DONE
    fifo.push_back(32'h0000_0001);
    fifo.push_back(32'h9000_0000);
    expect_ev(EV_START, 4'b0001, 32'h0000_0001);
    expect_ev(EV_TMO, 4'b0000, 32'h0);
    expect_ev(EV_START, 4'b0100, 32'h9000_0000);
    wait_rden("t5_pop");
    neg(3);
    chk("t5_vld", eng_vld, 4'b0001);
    neg(16);
    chk("t5_pre_tmo", {err_timeout, busy}, 2'b01);
    neg(1);
    chk("t5_tmo", err_timeout, 1'b1);
    neg(1);
    chk("t5_next_pop", {ff_rden, busy}, 2'b10);
    neg(3);
    chk("t5_vld_next", eng_vld, 4'b0100);
    neg(1);
    chk("t5_idle", busy, 1'b0);

    // async reset during WAIT_DONE
    fifo.push_back(32'h1000_0002);
    fifo.push_back(32'h9000_0004);
    expect_ev(EV_START, 4'b0010, 32'h1000_0002);
    expect_ev(EV_START, 4'b0100, 32'h9000_0004);
    wait_rden("t6_pop");
    neg(3);
    chk("t6_vld", eng_vld, 4'b0010);
    at_pos;
    eng_addr[1*AW +: AW] = 19'h7FFFF;
    eng_data[1*DW +: DW] = 8'hEE;
    eng_wren = 4'b0010;
    neg(1);
    chk("t6_pre_rst_wr", ram_wren, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_async", {busy, ram_wren, ram_addr, ram_data, eng_cmd, eng_vld, ff_rden}, '0);
    eng_wren = '0;
    eng_addr = '0;
    eng_data = '0;
    at_pos;
    at_pos;
    rst_n = 1'b1;
    neg(1);
    chk("t6_rel_pop", ff_rden, 1'b1);
    neg(3);
    chk("t6_vld", eng_vld, 4'b0100);
    neg(1);
    chk("t6_idle", busy, 1'b0);

    neg(3);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
